uart_rx_frame_parser: RTL
=========================

Name: uart_rx_frame_parser

Overview:
Downstream consumer of the UART receive controller. Takes each received byte (8-bit data plus a 1-cycle done pulse) and assembles command frames of the form HDR, LEN, payload[LEN], CSUM. It validates the checksum, then streams the payload out on a valid/ready interface toward the command decoder. Bad, truncated and overrun frames are reported on an error pulse with a code.

Parameters:
HDR_BYTE, 8'hAA, frame start marker
MAX_LEN, 16, maximum payload length in bytes (legal LEN is 1..MAX_LEN)
TIMEOUT_CYC, 50000, max sys_clk cycles between bytes inside a frame before abort

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from the UART RX controller, stable while rx_done is high
rx_done  input  1  1-cycle pulse marking rx_data valid
m_data  output  8  payload byte out
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts m_data
m_last  output  1  high with the final payload byte of a frame
frame_ok  output  1  1-cycle pulse: checksum matched, streaming begins next cycle
frame_err  output  1  1-cycle pulse: frame aborted or byte dropped
err_code  output  2  0=bad LEN, 1=checksum, 2=timeout, 3=overrun; held until next frame_err
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous): state IDLE; m_valid, m_last, frame_ok, frame_err, busy = 0; m_data = 0; err_code = 0; counters and checksum = 0. Reset mid-frame discards the frame and raises no error.
- Checksum: 8-bit sum mod 256 of LEN and all payload bytes; HDR is excluded. The frame is good when the sum equals CSUM.
- IDLE: on rx_done with rx_data == HDR_BYTE, go to LEN. Other bytes are ignored silently.
- LEN: on rx_done, if rx_data is 0 or greater than MAX_LEN, pulse frame_err with code 0 and return to IDLE. Otherwise store len, set sum = rx_data, set idx = 0, go to PAYLOAD.
- PAYLOAD: on rx_done, write buf[idx] = rx_data, add rx_data to sum, increment idx. When idx reaches len-1 on this write, go to CSUM.
- CSUM: on rx_done, if rx_data == sum, pulse frame_ok and go to OUTPUT with rd_idx = 0. Otherwise pulse frame_err with code 1 and return to IDLE.
- OUTPUT:
  - m_valid = 1, m_data = buf[rd_idx], m_last = (rd_idx == len-1).
  - A transfer completes on a cycle where m_valid and m_ready are both high. On transfer, rd_idx increments.
  - On the transfer with m_last high, drop m_valid and return to IDLE the next cycle.
  - m_data and m_last stay stable while m_valid is high and m_ready is low.
- Overrun: rx_done arriving in OUTPUT drops the byte and pulses frame_err with code 3. OUTPUT continues unaffected.
- Timeout:
  - The counter clears on every rx_done. It runs only in LEN, PAYLOAD and CSUM.
  - When the counter reaches TIMEOUT_CYC-1, pulse frame_err with code 2 and return to IDLE.
  - If rx_done arrives in the same cycle the counter would expire, the byte wins and no timeout is raised.
- Latency: frame_ok is high the cycle after the CSUM rx_done. m_valid is first high the cycle after frame_ok.
- The first frame_ok or frame_err pulse appears 1 cycle after the triggering rx_done. Pulses never overlap.
- Maximum buffer occupancy is MAX_LEN bytes. No new frame is accepted until OUTPUT completes.

Decomposition:
- Shared package uart_frame_pkg:
  - state enum {IDLE, LEN, PAYLOAD, CSUM, OUTPUT}
  - err_code constants ERR_LEN=0, ERR_CSUM=1, ERR_TMO=2, ERR_OVR=3
  - default HDR_BYTE
- One sub-module, frame_payload_buf: MAX_LEN x 8 register array, with a synchronous write port and a combinational read port addressed by rd_idx.
- FSM, checksum and timeout counter stay in the top module.

Test Plan:
- Good frame: AA 03 11 22 33 CSUM=69. Expect frame_ok, then m_data 11, 22, 33 with m_ready tied 1, m_last on 33, busy low afterwards.
- Backpressure: same frame with m_ready low for 5 cycles on each byte. Expect m_data and m_last held stable, exactly 3 transfers, order preserved.
- Bad checksum: AA 02 01 02 CSUM=00. Expect frame_err with err_code=1, no m_valid, return to IDLE. A following good frame is accepted.
- Bad length: AA 00, and AA 11 (17 > MAX_LEN). Expect frame_err with err_code=0 each time. Noise byte 55 in IDLE: no response.
- Timeout: AA 04 01, then silence for TIMEOUT_CYC cycles. Expect frame_err with err_code=2 exactly TIMEOUT_CYC-1 cycles after the last rx_done. A byte arriving on the expiry cycle produces no error.
- Overrun and reset: rx_done during OUTPUT with m_ready low gives frame_err with err_code=3 and payload intact. rst_n asserted mid-PAYLOAD sets all outputs to 0 immediately with no error pulse.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive frame parser.
//   - FSM state encodings (kept as plain constants for legacy tools)
//   - error codes reported on err_code
//   - default frame start marker
//   - checksum accumulation helper
package uart_frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LEN     = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_CSUM    = 3'd3;
  localparam state_t ST_OUTPUT  = 3'd4;

  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hAA;

  // Running checksum: plain 8-bit sum, wrapping mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] val);
    return acc + val;
  endfunction

endpackage

// File: rtl/frame_payload_buf.sv
// Payload storage for one command frame.
// Ports:
//   sys_clk, rst_n          clock, asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data  synchronous write port
//   i_rd_addr / o_rd_data   combinational read port
module frame_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [MAX_LEN];

  // Byte storage, cleared on reset so stale payload never leaks out.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles HDR, LEN, payload[LEN], CSUM frames from UART RX bytes,
// validates the checksum and streams the payload on valid/ready.
// Ports:
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   rx_data, rx_done      received byte and its 1-cycle strobe
//   m_data/m_valid/m_ready/m_last  payload stream toward the decoder
//   frame_ok              pulse: checksum good, streaming follows
//   frame_err, err_code   pulse on abort/drop, code held until next error
//   busy                  parser is not idle
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = DEF_HDR_BYTE,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  // The counter holds (silent cycles - 1). Expiry is decided when it hits
  // TIMEOUT_CYC-3 so the registered frame_err lands TIMEOUT_CYC-1 cycles
  // after the last byte.
  localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CYC - 3);

  state_t        r_state,    w_state_nxt;
  logic [LW-1:0] r_len,      w_len_nxt;
  logic [AW-1:0] r_idx,      w_idx_nxt;
  logic [AW-1:0] r_rd_idx,   w_rd_idx_nxt;
  logic [7:0]    r_sum,      w_sum_nxt;
  logic [TW-1:0] r_tmo_cnt,  w_tmo_cnt_nxt;
  logic [7:0]    r_m_data,   w_m_data_nxt;
  logic          r_m_valid,  w_m_valid_nxt;
  logic          r_m_last,   w_m_last_nxt;
  logic          r_frame_ok, w_frame_ok_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_busy;

  logic          w_wr_en;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_data;
  logic [AW-1:0] w_rd_idx_inc;
  logic          w_in_frame;
  logic          w_tmo_fire;
  logic          w_len_bad;
  logic          w_wr_last;

  frame_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_idx),
    .i_wr_data (rx_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_rd_idx_inc = r_rd_idx + AW'(1);
  // Look one entry ahead on a completed transfer so the next byte is
  // registered onto m_data without a bubble.
  assign w_rd_addr  = ((r_state == ST_OUTPUT) && r_m_valid && m_ready) ? w_rd_idx_inc : r_rd_idx;
  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  // A byte on the expiry cycle takes priority over the timeout.
  assign w_tmo_fire = w_in_frame && !rx_done && (r_tmo_cnt == TMO_FIRE);
  assign w_len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
  assign w_wr_last  = (LW'(r_idx) == (r_len - LW'(1)));

  // Next-state and output decode for the frame FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_rd_idx_nxt    = r_rd_idx;
    w_sum_nxt       = r_sum;
    w_m_data_nxt    = r_m_data;
    w_m_valid_nxt   = r_m_valid;
    w_m_last_nxt    = r_m_last;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_wr_en         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rx_done && (rx_data == HDR_BYTE)) begin
          w_state_nxt = ST_LEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          if (w_len_bad) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_LEN;
            w_state_nxt     = ST_IDLE;
          end else begin
            w_len_nxt   = rx_data[LW-1:0];
            w_sum_nxt   = rx_data;
            w_idx_nxt   = '0;
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_tmo_fire) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TMO;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          w_wr_en   = 1'b1;
          w_sum_nxt = csum_add(r_sum, rx_data);
          w_idx_nxt = r_idx + AW'(1);
          if (w_wr_last) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_tmo_fire) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TMO;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (rx_done) begin
          if (rx_data == r_sum) begin
            w_frame_ok_nxt = 1'b1;
            w_rd_idx_nxt   = '0;
            w_state_nxt    = ST_OUTPUT;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_CSUM;
            w_state_nxt     = ST_IDLE;
          end
        end else if (w_tmo_fire) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_TMO;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
      ST_OUTPUT: begin
        // Any byte arriving while streaming is dropped and flagged.
        if (rx_done) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = ERR_OVR;
        end else begin
          w_frame_err_nxt = 1'b0;
        end
        // m_valid low here means this is the first cycle of OUTPUT.
        if (!r_m_valid) begin
          w_m_valid_nxt = 1'b1;
          w_m_data_nxt  = w_rd_data;
          w_m_last_nxt  = (LW'(r_rd_idx) == (r_len - LW'(1)));
        end else if (m_ready) begin
          if (r_m_last) begin
            w_m_valid_nxt = 1'b0;
            w_m_last_nxt  = 1'b0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_rd_idx_nxt = w_rd_idx_inc;
            w_m_data_nxt = w_rd_data;
            w_m_last_nxt = (LW'(w_rd_idx_inc) == (r_len - LW'(1)));
          end
        end else begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_m_valid_nxt = 1'b0;
        w_m_last_nxt  = 1'b0;
      end
    endcase
  end

  // Inter-byte timeout counter, only running while a frame is being received.
  always_comb begin
    if (rx_done || w_tmo_fire) begin
      w_tmo_cnt_nxt = '0;
    end else if (w_in_frame) begin
      w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
    end else begin
      w_tmo_cnt_nxt = '0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_sum       <= 8'd0;
      r_tmo_cnt   <= '0;
      r_m_data    <= 8'd0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_sum       <= w_sum_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_last    <= w_m_last_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;

endmodule
